// File: rtl/led_flow_ctrl_pkg.sv
// Shared definitions for the LED flow controller slice.
//   mode_t  : pattern mode encodings as seen on the 2-bit mode port
//   state_t : one-hot controller state encodings
//   led_off : all-off pin pattern for a given pin polarity (LED_MAX wide)
package led_pkg;

   localparam int unsigned LED_MAX = 32;

   typedef enum logic [1:0] {
      MODE_UP    = 2'b00,
      MODE_DOWN  = 2'b01,
      MODE_PING  = 2'b10,
      MODE_BLINK = 2'b11
   } mode_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RUN  = 3'b010,
      ST_DONE = 3'b100
   } state_t;

   // Active-low pins are dark when driven high.
   function automatic logic [LED_MAX-1:0] led_off(input logic active_low);
      return active_low ? '1 : '0;
   endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step timer for the LED flow controller.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   run  : count while high; counter is held at zero while low
//   tick : high for the cycle in which the counter equals CNT_MAX
module led_step_timer #(
   parameter int unsigned CNT_MAX = 24_999_999,
   parameter int unsigned CNT_W   = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = run && (cnt == CNT_W'(CNT_MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!run || tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/led_flow_ctrl.sv
// Parametrised LED chaser for the vending-machine status panel.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : level request, pattern runs while high
//   mode : 00 up-chase, 01 down-chase, 10 ping-pong, 11 blink-all
//   led  : registered LED pin drive, polarity set by ACTIVE_LOW
//   busy : registered, high while in RUN
//   done : registered one-cycle pulse when RUN_STEPS steps have elapsed
module led_flow_ctrl
   import led_pkg::*;
#(
   parameter int unsigned LED_NUM    = 4,
   parameter int unsigned CNT_MAX    = 24_999_999,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned RUN_STEPS  = 0,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   output logic [LED_NUM-1:0] led,
   output logic               busy,
   output logic               done
);

   localparam int unsigned POS_W  = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
   localparam int unsigned STEP_W = (RUN_STEPS > 0) ? $clog2(RUN_STEPS + 1) : 1;

   localparam logic [LED_MAX-1:0] OFF_ALL  = led_off(ACTIVE_LOW);
   localparam logic [LED_NUM-1:0] LED_OFF  = OFF_ALL[LED_NUM-1:0];
   localparam logic [POS_W-1:0]   POS_LAST = POS_W'(LED_NUM - 1);

   state_t              state_q, state_d;
   mode_t               mode_q,  mode_d;
   logic [POS_W-1:0]    pos_q,   pos_d;
   logic                dir_up_q, dir_up_d;
   logic                blink_q, blink_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [LED_NUM-1:0]  led_q,   led_d;
   logic                busy_q,  busy_d;
   logic                done_q,  done_d;
   logic                tick;
   logic                run;

   // Gating with en clears the timer on the same edge an abort leaves RUN.
   assign run = (state_q == ST_RUN) && en;

   led_step_timer #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      pos_d    = pos_q;
      dir_up_d = dir_up_q;
      blink_d  = blink_q;
      steps_d  = steps_q;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            steps_d = '0;
            if (en) begin
               state_d  = ST_RUN;
               mode_d   = mode_t'(mode);
               blink_d  = 1'b1;
               dir_up_d = 1'b1;
               pos_d    = (mode_t'(mode) == MODE_DOWN) ? POS_LAST : '0;
            end
         end

         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               steps_d = steps_q + STEP_W'(1);
               if ((RUN_STEPS != 0) && ((32'(steps_q) + 32'd1) == RUN_STEPS)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  case (mode_q)
                     MODE_UP:   pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                     MODE_DOWN: pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                     MODE_PING: begin
                        // Reverse and step away in one tick so an end LED never repeats.
                        if (dir_up_q) begin
                           if (pos_q == POS_LAST) begin
                              dir_up_d = 1'b0;
                              pos_d    = pos_q - POS_W'(1);
                           end else begin
                              pos_d    = pos_q + POS_W'(1);
                           end
                        end else begin
                           if (pos_q == '0) begin
                              dir_up_d = 1'b1;
                              pos_d    = POS_W'(1);
                           end else begin
                              pos_d    = pos_q - POS_W'(1);
                           end
                        end
                     end
                     default:   blink_d = ~blink_q;
                  endcase
               end
            end
         end

         ST_DONE: begin
            if (!en)
               state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Output decode from next-state values so pins change on the state edge.
      busy_d = (state_d == ST_RUN);
      if (state_d != ST_RUN)
         led_d = LED_OFF;
      else if (mode_d == MODE_BLINK)
         led_d = blink_d ? ~LED_OFF : LED_OFF;
      else
         led_d = (LED_NUM'(1) << pos_d) ^ LED_OFF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_UP;
         pos_q    <= '0;
         dir_up_q <= 1'b1;
         blink_q  <= 1'b0;
         steps_q  <= '0;
         led_q    <= LED_OFF;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         pos_q    <= pos_d;
         dir_up_q <= dir_up_d;
         blink_q  <= blink_d;
         steps_q  <= steps_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign led  = led_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: three instances share clk/rst/en/mode.
//   A: ACTIVE_LOW=1, free-running   B: ACTIVE_LOW=0   C: ACTIVE_LOW=1, RUN_STEPS=5
module tb_led_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] mode;

   logic [3:0] led_a, led_b, led_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   led_flow_ctrl #(.LED_NUM(4), .CNT_MAX(3), .CNT_W(4), .RUN_STEPS(0), .ACTIVE_LOW(1'b1)) u_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led_a), .busy(busy_a), .done(done_a));
   led_flow_ctrl #(.LED_NUM(4), .CNT_MAX(3), .CNT_W(4), .RUN_STEPS(0), .ACTIVE_LOW(1'b0)) u_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led_b), .busy(busy_b), .done(done_b));
   led_flow_ctrl #(.LED_NUM(4), .CNT_MAX(3), .CNT_W(4), .RUN_STEPS(5), .ACTIVE_LOW(1'b1)) u_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .led(led_c), .busy(busy_c), .done(done_c));

   typedef struct packed {
      logic [1:0]       sel;
      logic [1:0]       mode;
      logic [0:7][3:0]  seq;
   } vec_t;

   typedef struct packed {
      logic [1:0] sel;
      logic [5:0] exp;
   } sb_t;

   sb_t sb[$];
   vec_t tbl[6];

   function automatic logic [5:0] cur(input logic [1:0] sel);
      case (sel)
         2'd0:    return {led_a, busy_a, done_a};
         2'd1:    return {led_b, busy_b, done_b};
         default: return {led_c, busy_c, done_c};
      endcase
   endfunction

   function automatic logic [3:0] off_of(input logic [1:0] sel);
      return (sel == 2'd1) ? 4'b0000 : 4'b1111;
   endfunction

   task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got led/busy/done=%b required %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Push the expectation for the next clock, then pop it once the DUT has produced it.
   task automatic cyc_check(input logic [1:0] sel, input logic [3:0] l, input logic b,
                            input logic d, input string nm);
      sb_t item;
      sb.push_back('{sel: sel, exp: {l, b, d}});
      @(negedge clk);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         item = sb.pop_front();
         chk(nm, cur(item.sel), item.exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [0:4][3:0] down5;
      down5 = {4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111};

      tbl[0] = '{sel: 2'd0, mode: 2'b00, seq: {4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                               4'b1110, 4'b1101, 4'b1011, 4'b0111}};
      tbl[1] = '{sel: 2'd0, mode: 2'b01, seq: {4'b0111, 4'b1011, 4'b1101, 4'b1110,
                                               4'b0111, 4'b1011, 4'b1101, 4'b1110}};
      tbl[2] = '{sel: 2'd0, mode: 2'b10, seq: {4'b1110, 4'b1101, 4'b1011, 4'b0111,
                                               4'b1011, 4'b1101, 4'b1110, 4'b1101}};
      tbl[3] = '{sel: 2'd0, mode: 2'b11, seq: {4'b0000, 4'b1111, 4'b0000, 4'b1111,
                                               4'b0000, 4'b1111, 4'b0000, 4'b1111}};
      tbl[4] = '{sel: 2'd1, mode: 2'b11, seq: {4'b1111, 4'b0000, 4'b1111, 4'b0000,
                                               4'b1111, 4'b0000, 4'b1111, 4'b0000}};
      tbl[5] = '{sel: 2'd1, mode: 2'b00, seq: {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                               4'b0001, 4'b0010, 4'b0100, 4'b1000}};

      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'b00;

      // Reset state
      @(negedge clk);
      chk("reset_a", cur(2'd0), {4'b1111, 1'b0, 1'b0});
      chk("reset_b", cur(2'd1), {4'b0000, 1'b0, 1'b0});
      chk("reset_c", cur(2'd2), {4'b1111, 1'b0, 1'b0});
      rst = 1'b0;
      cyc_check(2'd0, 4'b1111, 1'b0, 1'b0, "idle_hold");

      // Table-driven pattern runs, each from IDLE
      for (int e = 0; e < 6; e++) begin
         mode = tbl[e].mode;
         en   = 1'b1;
         chk("start_off", cur(tbl[e].sel), {off_of(tbl[e].sel), 1'b0, 1'b0});
         for (int k = 0; k < 32; k++)
            cyc_check(tbl[e].sel, tbl[e].seq[k/4], 1'b1, 1'b0, $sformatf("vec%0d_cyc%0d", e, k));
         en = 1'b0;
         cyc_check(tbl[e].sel, off_of(tbl[e].sel), 1'b0, 1'b0, $sformatf("vec%0d_abort", e));
      end

      // Asynchronous reset in the middle of a run
      mode = 2'b00;
      en   = 1'b1;
      for (int k = 0; k < 6; k++)
         cyc_check(2'd0, (k < 4) ? 4'b1110 : 4'b1101, 1'b1, 1'b0, "prerst_run");
      #2 rst = 1'b1;
      #1 chk("rst_midrun", cur(2'd0), {4'b1111, 1'b0, 1'b0});
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc_check(2'd0, 4'b1111, 1'b0, 1'b0, "rst_release_idle");
      en = 1'b1;
      cyc_check(2'd0, 4'b1110, 1'b1, 1'b0, "rst_restart");
      en = 1'b0;
      cyc_check(2'd0, 4'b1111, 1'b0, 1'b0, "rst_restart_drop");

      // Finite run: five steps then DONE, held while en stays high
      mode = 2'b01;
      en   = 1'b1;
      for (int k = 0; k < 20; k++)
         cyc_check(2'd2, down5[k/4], 1'b1, 1'b0, $sformatf("steps_cyc%0d", k));
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b1, "done_pulse");
      for (int k = 0; k < 6; k++)
         cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "done_hold");
      en = 1'b0;
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "done_to_idle");
      en = 1'b1;
      cyc_check(2'd2, 4'b0111, 1'b1, 1'b0, "done_restart");
      en = 1'b0;
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "done_restart_drop");

      // en falls in the final tick cycle, mode changed mid-run
      mode = 2'b01;
      en   = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (k == 9)
            mode = 2'b00;
         cyc_check(2'd2, down5[k/4], 1'b1, 1'b0, $sformatf("abort_cyc%0d", k));
      end
      en = 1'b0;
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "tick_vs_en");
      chk("tick_vs_en_a", cur(2'd0), {4'b1111, 1'b0, 1'b0});
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "no_late_done");
      en = 1'b1;
      cyc_check(2'd2, 4'b1110, 1'b1, 1'b0, "new_mode_applied");
      en = 1'b0;
      cyc_check(2'd2, 4'b1111, 1'b0, 1'b0, "final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
